// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT core.
// Controller state encoding is also exported on state_dbg.
package fft_pkg;

  localparam int FFT_N            = 16;
  localparam int BFLY_LATENCY_DEF = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    LOAD      = 3'd2,
    WAIT      = 3'd3,
    WRITE     = 3'd4,
    NEXT      = 3'd5,
    SHIFT_OUT = 3'd6,
    DONE      = 3'd7
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_controller_if.sv
// Flag-to-enable link between fft_controller and timers.
// The controller drives enables, timers returns done flags.
interface fft_controller_if;

  logic shift_in_ena;
  logic load_ena;
  logic write_ena;
  logic iteration_ena;
  logic shift_out_ena;

  logic samples_in_done;
  logic samples_loaded_done;
  logic samples_written_done;
  logic fft_done;
  logic samples_out_done;

  modport master (
    output shift_in_ena,
    output load_ena,
    output write_ena,
    output iteration_ena,
    output shift_out_ena,
    input  samples_in_done,
    input  samples_loaded_done,
    input  samples_written_done,
    input  fft_done,
    input  samples_out_done
  );

  modport slave (
    input  shift_in_ena,
    input  load_ena,
    input  write_ena,
    input  iteration_ena,
    input  shift_out_ena,
    output samples_in_done,
    output samples_loaded_done,
    output samples_written_done,
    output fft_done,
    output samples_out_done
  );

endinterface

// File: rtl/fft_controller.sv
// Frame sequencer for the 16-point FFT datapath:
// shift-in, butterfly rounds, shift-out, done.
module fft_controller
  import fft_pkg::*;
#(
  parameter int BFLY_LATENCY = BFLY_LATENCY_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_valid,
  input  logic             out_ready,
  fft_controller_if.master tmr,
  output logic             busy,
  output logic             frame_done,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] WAIT_INIT =
    3'(BFLY_LATENCY - 1);

  fft_ctrl_state_t state;
  fft_ctrl_state_t state_n;
  logic [2:0]      wait_cnt;
  logic [2:0]      wait_n;

  logic si_en;
  logic ld_en;
  logic wr_en;
  logic it_en;
  logic so_en;
  logic fd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    si_en   = 1'b0;
    ld_en   = 1'b0;
    wr_en   = 1'b0;
    it_en   = 1'b0;
    so_en   = 1'b0;
    fd      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = SHIFT_IN;
      end
      SHIFT_IN: begin
        si_en = sample_valid;
        if (tmr.samples_in_done && sample_valid)
          state_n = LOAD;
      end
      LOAD: begin
        ld_en = 1'b1;
        if (tmr.samples_loaded_done) begin
          wait_n  = WAIT_INIT;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 3'd0) state_n = WRITE;
        else wait_n = wait_cnt - 3'd1;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (tmr.samples_written_done)
          state_n = NEXT;
      end
      NEXT: begin
        it_en   = 1'b1;
        state_n = tmr.fft_done ? SHIFT_OUT : LOAD;
      end
      SHIFT_OUT: begin
        so_en = out_ready;
        if (tmr.samples_out_done && out_ready)
          state_n = DONE;
      end
      DONE: begin
        fd      = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // abort outranks every transition, start included
    if (abort) begin
      state_n = IDLE;
      wait_n  = 3'd0;
    end
  end

  assign tmr.shift_in_ena  = si_en;
  assign tmr.load_ena      = ld_en;
  assign tmr.write_ena     = wr_en;
  assign tmr.iteration_ena = it_en;
  assign tmr.shift_out_ena = so_en;

  assign busy       = (state != IDLE);
  assign frame_done = fd;
  assign state_dbg  = state;

endmodule

// File: tb/tb_fft_controller.sv
// Directed bench: three controllers (latency 2, 1, 7)
// each paired with a small timers model.
module tb_fft_controller;

  logic tb_clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic sample_valid;
  logic out_ready;
  logic mclr;
  logic inj_in_done;
  logic inj_out_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tb_clk = ~tb_clk;

  for (genvar g = 0; g < 3; g++) begin : m
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 7;

    fft_controller_if tif ();
    logic       busy;
    logic       frame_done;
    logic [2:0] state_dbg;

    logic [3:0] c_in;
    logic [3:0] c_out;
    logic [2:0] c_ld;
    logic [1:0] c_wr;
    int         c_it;

    int   n_in, n_ld, n_wr, n_it, n_out, n_fd;
    int   since, gap;
    logic wr_prev;

    fft_controller #(.BFLY_LATENCY(LAT)) dut (
      .clk          (tb_clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .sample_valid (sample_valid),
      .out_ready    (out_ready),
      .tmr          (tif),
      .busy         (busy),
      .frame_done   (frame_done),
      .state_dbg    (state_dbg)
    );

    assign tif.samples_in_done =
      (tif.shift_in_ena && c_in == 4'd15) ||
      (g == 0 && inj_in_done);
    assign tif.samples_loaded_done =
      tif.load_ena && c_ld == 3'd7;
    assign tif.samples_written_done =
      tif.write_ena && c_wr == 2'd3;
    assign tif.fft_done = (c_it == 2);
    assign tif.samples_out_done =
      (tif.shift_out_ena && c_out == 4'd15) ||
      (g == 0 && inj_out_done);

    always_ff @(posedge tb_clk or posedge rst) begin
      if (rst || mclr) begin
        c_in    <= 4'd0;
        c_out   <= 4'd0;
        c_ld    <= 3'd0;
        c_wr    <= 2'd0;
        c_it    <= 0;
        n_in    <= 0;
        n_ld    <= 0;
        n_wr    <= 0;
        n_it    <= 0;
        n_out   <= 0;
        n_fd    <= 0;
        since   <= 0;
        gap     <= -1;
        wr_prev <= 1'b0;
      end else begin
        if (tif.shift_in_ena) begin
          c_in <= c_in + 4'd1;
          n_in <= n_in + 1;
        end
        if (tif.load_ena) begin
          c_ld <= c_ld + 3'd1;
          n_ld <= n_ld + 1;
        end
        if (tif.write_ena) begin
          c_wr <= c_wr + 2'd1;
          n_wr <= n_wr + 1;
        end
        if (tif.shift_out_ena) begin
          c_out <= c_out + 4'd1;
          n_out <= n_out + 1;
        end
        if (tif.iteration_ena) begin
          c_it <= c_it + 1;
          n_it <= n_it + 1;
        end
        if (frame_done) begin
          c_it <= 0;
          n_fd <= n_fd + 1;
        end
        if (tif.load_ena) since <= 0;
        else since <= since + 1;
        if (tif.write_ena && !wr_prev) gap <= since;
        wr_prev <= tif.write_ena;
      end
    end
  end

  logic [6:0] outs0;
  assign outs0 = {m[0].tif.shift_in_ena,
                  m[0].tif.load_ena,
                  m[0].tif.write_ena,
                  m[0].tif.iteration_ena,
                  m[0].tif.shift_out_ena,
                  m[0].frame_done,
                  m[0].busy};

  logic all_done;
  assign all_done = m[0].n_fd > 0 &&
                    m[1].n_fd > 0 &&
                    m[2].n_fd > 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge tb_clk);
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input int budget,
                            input string tag);
    int k = 0;
    while (m[0].state_dbg != s && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(m[0].state_dbg), 32'(s));
  endtask

  task automatic wait_frames(input int budget,
                             input string tag);
    int k = 0;
    while (!all_done && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(all_done), 32'd1);
  endtask

  task automatic clear_model();
    mclr = 1'b1;
    step();
    mclr = 1'b0;
  endtask

  task automatic chk_frame0(input string tag);
    chk({tag, "_in"},  32'(m[0].n_in),  32'd16);
    chk({tag, "_ld"},  32'(m[0].n_ld),  32'd24);
    chk({tag, "_wr"},  32'(m[0].n_wr),  32'd12);
    chk({tag, "_it"},  32'(m[0].n_it),  32'd3);
    chk({tag, "_out"}, 32'(m[0].n_out), 32'd16);
    chk({tag, "_fd"},  32'(m[0].n_fd),  32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    sample_valid = 1'b0;
    out_ready    = 1'b0;
    mclr         = 1'b0;
    inj_in_done  = 1'b0;
    inj_out_done = 1'b0;
    repeat (2) step();

    chk("rst_state", 32'(m[0].state_dbg), 32'd0);
    chk("rst_outs", 32'(outs0), 32'd0);
    chk("rst_wait", 32'(m[0].dut.wait_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) step();
    chk("idle_hold", 32'(m[0].state_dbg), 32'd0);

    // full frame on all three latencies
    sample_valid = 1'b1;
    out_ready    = 1'b1;
    start        = 1'b1;
    #1;
    chk("idle_no_shift",
        32'(m[0].tif.shift_in_ena), 32'd0);
    step();
    start = 1'b0;
    chk("start_lat",
        32'(m[0].tif.shift_in_ena), 32'd1);
    chk("start_state", 32'(m[0].state_dbg), 32'd1);
    wait_frames(1000, "frame1_done");
    repeat (3) step();
    chk_frame0("f1");
    chk("f1_idle", 32'(m[0].state_dbg), 32'd0);
    chk("gap_lat2", 32'(m[0].gap), 32'd2);
    chk("gap_lat1", 32'(m[1].gap), 32'd1);
    chk("gap_lat7", 32'(m[2].gap), 32'd7);
    chk("lat1_ld", 32'(m[1].n_ld), 32'd24);
    chk("lat7_ld", 32'(m[2].n_ld), 32'd24);
    chk("lat7_fd", 32'(m[2].n_fd), 32'd1);

    // reset in LOAD
    clear_model();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_state(3'd2, 100, "to_load");
    rst = 1'b1;
    #1;
    chk("mid_rst_state", 32'(m[0].state_dbg), 32'd0);
    chk("mid_rst_outs", 32'(outs0), 32'd0);
    step();
    rst = 1'b0;
    repeat (2) step();
    chk("post_rst_idle", 32'(m[0].state_dbg), 32'd0);

    // sample_valid gating in SHIFT_IN
    sample_valid = 1'b0;
    start        = 1'b1;
    step();
    start = 1'b0;
    chk("sv_state", 32'(m[0].state_dbg), 32'd1);
    sample_valid = 1'b1;
    #1 chk("sv_1a", 32'(m[0].tif.shift_in_ena), 32'd1);
    step();
    sample_valid = 1'b0;
    #1 chk("sv_0a", 32'(m[0].tif.shift_in_ena), 32'd0);
    step();
    sample_valid = 1'b1;
    #1 chk("sv_1b", 32'(m[0].tif.shift_in_ena), 32'd1);
    step();
    sample_valid = 1'b0;
    #1 chk("sv_0b", 32'(m[0].tif.shift_in_ena), 32'd0);
    inj_in_done = 1'b1;
    #1 chk("sv_done_gate",
           32'(m[0].tif.shift_in_ena), 32'd0);
    step();
    inj_in_done = 1'b0;
    chk("sv_done_hold", 32'(m[0].state_dbg), 32'd1);
    chk("sv_count", 32'(m[0].n_in), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("sv_abort", 32'(m[0].state_dbg), 32'd0);
    clear_model();

    // abort with start in WAIT, then in IDLE
    sample_valid = 1'b1;
    out_ready    = 1'b1;
    start        = 1'b1;
    step();
    start = 1'b0;
    wait_state(3'd3, 200, "to_wait");
    chk("wait_cnt_live",
        32'(m[0].dut.wait_cnt), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    step();
    chk("abort_state", 32'(m[0].state_dbg), 32'd0);
    chk("abort_outs", 32'(outs0), 32'd0);
    chk("abort_wait", 32'(m[0].dut.wait_cnt), 32'd0);
    step();
    chk("abort_idle_start",
        32'(m[0].state_dbg), 32'd0);
    abort = 1'b0;
    start = 1'b0;
    clear_model();
    chk("abort_stay", 32'(m[0].state_dbg), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_frames(1000, "frame2_done");
    repeat (2) step();
    chk_frame0("f2");

    // stray flags and start while busy
    clear_model();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_state(3'd2, 100, "to_load2");
    inj_out_done = 1'b1;
    step();
    inj_out_done = 1'b0;
    chk("stray_out", 32'(m[0].state_dbg), 32'd2);
    wait_state(3'd4, 100, "to_write");
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start", 32'(m[0].state_dbg), 32'd4);
    wait_frames(1000, "frame3_done");
    repeat (2) step();
    chk_frame0("f3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
